// File: rtl/exec_stage.sv
// Execute stage: single-cycle ops, iterative RV32M unit and a load/store bus port.
// Redirects open a shadow window that silently drops the next accepted instructions.
module exec_stage #(
  parameter int MULDIV_EN = 1,
  parameter int SHADOW    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_r1,
  input  logic [31:0] in_r2,
  input  logic [31:0] in_alu_res,
  input  logic [31:0] in_jmp_addr,
  output logic        q_valid,
  input  logic        q_ready,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc,
  output logic [31:0] q_res,
  output logic        q_write_rd,
  output logic        q_misalign,
  output logic        redirect,
  output logic [31:0] redirect_addr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  output logic [3:0]  bus_lanes,
  output logic        bus_wr,
  output logic        bus_valid,
  input  logic        bus_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MULDIV = 2'd1;
  localparam logic [1:0] MEM    = 2'd2;

  logic [1:0]  state;
  logic [2:0]  kill;
  logic [1:0]  mem_off;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        is_m, is_ld, is_st, is_mem;
  logic        is_jal, is_jalr, is_br;
  logic [31:0] imm_i, imm_s, addr;
  logic        misal, taken, jump;
  logic [31:0] target, one_res, wdata;
  logic [3:0]  lanes;
  logic        one_wr;
  logic        acc, live, go_md, go_mem;

  assign opc     = in_instr[6:0];
  assign f3      = in_instr[14:12];
  assign rd      = in_instr[11:7];
  assign is_m    = (opc == 7'h33) && (in_instr[31:25] == 7'b0000001);
  assign is_ld   = (opc == 7'h03);
  assign is_st   = (opc == 7'h23);
  assign is_mem  = is_ld || is_st;
  assign is_jal  = (opc == 7'h6F);
  assign is_jalr = (opc == 7'h67);
  assign is_br   = (opc == 7'h63);

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign addr  = in_r1 + (is_st ? imm_s : imm_i);

  assign misal = ((f3[1:0] == 2'b01) && addr[0])
              || (f3[1] && (addr[1:0] != 2'b00));

  assign in_ready = (state == IDLE) && (!q_valid || q_ready);
  assign acc      = in_valid && in_ready;
  assign live     = acc && (kill == 3'd0);
  assign go_md    = live && is_m && (MULDIV_EN != 0);
  assign go_mem   = live && is_mem && !misal;

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = (in_r1 == in_r2);
      3'b001:  taken = (in_r1 != in_r2);
      3'b100:  taken = ($signed(in_r1) <  $signed(in_r2));
      3'b101:  taken = ($signed(in_r1) >= $signed(in_r2));
      3'b110:  taken = (in_r1 <  in_r2);
      3'b111:  taken = (in_r1 >= in_r2);
      default: taken = 1'b0;
    endcase
  end

  assign jump   = is_jal || is_jalr || (is_br && taken);
  assign target = is_jalr ? ((in_r1 + imm_i) & ~32'd1) : in_jmp_addr;

  always_comb begin
    lanes = 4'b1111;
    wdata = in_r2;
    case (f3[1:0])
      2'b00: begin
        lanes = 4'b0001 << addr[1:0];
        wdata = {4{in_r2[7:0]}};
      end
      2'b01: begin
        lanes = 4'b0011 << addr[1:0];
        wdata = {2{in_r2[15:0]}};
      end
      default: ;
    endcase
  end

  // Misaligned accesses retire here with the faulting address as result.
  always_comb begin
    one_res = in_alu_res;
    unique case (1'b1)
      is_m:              one_res = 32'd0;
      is_jal || is_jalr: one_res = in_pc + 32'd4;
      is_mem:            one_res = addr;
      default: ;
    endcase
  end

  assign one_wr = (rd != 5'd0) && !is_br && !is_st
               && (opc != 7'h0F) && !(is_mem && misal);

  // Iterative multiply/divide on operand magnitudes.
  logic [31:0] md_hi, md_lo, md_b, md_a;
  logic [4:0]  md_cnt;
  logic [2:0]  md_f3;
  logic        md_neg, md_rneg, md_dz;
  logic        a_sg, b_sg, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_sh;
  logic [31:0] div_diff, md_hi_n, md_lo_n, quo, rem, md_res;
  logic [63:0] prod, prod_s;
  logic        div_ge, md_last;

  assign a_sg  = f3[2] ? !f3[0] : (f3[1:0] == 2'b01) || (f3[1:0] == 2'b10);
  assign b_sg  = f3[2] ? !f3[0] : (f3[1:0] == 2'b01);
  assign a_neg = a_sg && in_r1[31];
  assign b_neg = b_sg && in_r2[31];
  assign a_mag = a_neg ? -in_r1 : in_r1;
  assign b_mag = b_neg ? -in_r2 : in_r2;

  assign mul_sum  = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : 33'd0);
  assign div_sh   = {md_hi, md_lo[31]};
  assign div_ge   = div_sh >= {1'b0, md_b};
  assign div_diff = div_sh[31:0] - md_b;

  assign md_hi_n = md_f3[2] ? (div_ge ? div_diff : div_sh[31:0])
                            : mul_sum[32:1];
  assign md_lo_n = md_f3[2] ? {md_lo[30:0], div_ge}
                            : {mul_sum[0], md_lo[31:1]};

  assign prod    = {md_hi_n, md_lo_n};
  assign prod_s  = md_neg ? -prod : prod;
  assign quo     = md_neg ? -md_lo_n : md_lo_n;
  assign rem     = md_rneg ? -md_hi_n : md_hi_n;
  assign md_last = (md_cnt == 5'd31);

  always_comb begin
    md_res = prod_s[63:32];
    if (!md_f3[2]) begin
      if (md_f3[1:0] == 2'b00) md_res = prod_s[31:0];
    end else if (md_dz) begin
      md_res = md_f3[1] ? md_a : 32'hFFFF_FFFF;
    end else begin
      md_res = md_f3[1] ? rem : quo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_hi   <= '0;
      md_lo   <= '0;
      md_b    <= '0;
      md_a    <= '0;
      md_cnt  <= '0;
      md_f3   <= '0;
      md_neg  <= 1'b0;
      md_rneg <= 1'b0;
      md_dz   <= 1'b0;
    end else if (go_md) begin
      md_hi   <= '0;
      md_lo   <= f3[2] ? a_mag : b_mag;
      md_b    <= f3[2] ? b_mag : a_mag;
      md_a    <= in_r1;
      md_cnt  <= '0;
      md_f3   <= f3;
      md_neg  <= a_neg ^ b_neg;
      md_rneg <= f3[2] && a_neg;
      md_dz   <= f3[2] && (in_r2 == 32'd0);
    end else if (state == MULDIV) begin
      md_hi  <= md_hi_n;
      md_lo  <= md_lo_n;
      md_cnt <= md_cnt + 5'd1;
    end
  end

  logic [31:0] ld_sh, ld_data;

  assign ld_sh = bus_din >> {mem_off, 3'b000};

  always_comb begin
    ld_data = ld_sh;
    case (q_instr[13:12])
      2'b00:   ld_data = {{24{ld_sh[7] & ~q_instr[14]}}, ld_sh[7:0]};
      2'b01:   ld_data = {{16{ld_sh[15] & ~q_instr[14]}}, ld_sh[15:0]};
      default: ld_data = ld_sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      kill          <= '0;
      mem_off       <= '0;
      q_valid       <= 1'b0;
      q_instr       <= '0;
      q_pc          <= '0;
      q_res         <= '0;
      q_write_rd    <= 1'b0;
      q_misalign    <= 1'b0;
      redirect      <= 1'b0;
      redirect_addr <= '0;
      bus_addr      <= '0;
      bus_dout      <= '0;
      bus_lanes     <= '0;
      bus_wr        <= 1'b0;
      bus_valid     <= 1'b0;
    end else begin
      redirect <= 1'b0;
      if (q_ready) q_valid <= 1'b0;
      if (acc && (kill != 3'd0)) begin
        kill <= kill - 3'd1;
      end else if (live) begin
        q_instr <= in_instr;
        q_pc    <= in_pc;
        if (jump) begin
          redirect      <= 1'b1;
          redirect_addr <= target;
          kill          <= 3'(SHADOW);
        end
        if (go_md) begin
          state <= MULDIV;
        end else if (go_mem) begin
          state     <= MEM;
          bus_valid <= 1'b1;
          bus_wr    <= is_st;
          bus_addr  <= {addr[31:2], 2'b00};
          bus_lanes <= lanes;
          bus_dout  <= wdata;
          mem_off   <= addr[1:0];
        end else begin
          q_valid    <= 1'b1;
          q_res      <= one_res;
          q_write_rd <= one_wr;
          q_misalign <= is_mem && misal;
        end
      end
      if ((state == MULDIV) && md_last) begin
        state      <= IDLE;
        q_valid    <= 1'b1;
        q_res      <= md_res;
        q_write_rd <= (q_instr[11:7] != 5'd0);
        q_misalign <= 1'b0;
      end
      if ((state == MEM) && bus_ready) begin
        state      <= IDLE;
        bus_valid  <= 1'b0;
        bus_wr     <= 1'b0;
        q_valid    <= 1'b1;
        q_res      <= q_instr[5] ? 32'd0 : ld_data;
        q_write_rd <= !q_instr[5] && (q_instr[11:7] != 5'd0);
        q_misalign <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: handshake, redirect shadow, RV32M,
// load/store lanes, misalignment and reset mid-operation.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_r1 = '0;
  logic [31:0] in_r2 = '0;
  logic [31:0] in_alu_res = '0;
  logic [31:0] in_jmp_addr = '0;
  logic        q_valid;
  logic        q_ready = 1'b1;
  logic [31:0] q_instr, q_pc, q_res;
  logic        q_write_rd, q_misalign;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] bus_addr, bus_dout;
  logic [31:0] bus_din = '0;
  logic [3:0]  bus_lanes;
  logic        bus_wr, bus_valid;
  logic        bus_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  exec_stage #(.MULDIV_EN(1), .SHADOW(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_r1(in_r1), .in_r2(in_r2),
    .in_alu_res(in_alu_res), .in_jmp_addr(in_jmp_addr),
    .q_valid(q_valid), .q_ready(q_ready),
    .q_instr(q_instr), .q_pc(q_pc), .q_res(q_res),
    .q_write_rd(q_write_rd), .q_misalign(q_misalign),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
    .bus_lanes(bus_lanes), .bus_wr(bus_wr),
    .bus_valid(bus_valid), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] itype(input logic [11:0] imm,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, 5'd1, f3, rd, op};
  endfunction

  function automatic logic [31:0] stype(input logic [11:0] imm,
      input logic [2:0] f3);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] mtype(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd10, 7'h33};
  endfunction

  function automatic logic [31:0] btype(input logic [2:0] f3);
    return {7'd0, 5'd2, 5'd1, f3, 5'd7, 7'h63};
  endfunction

  // Present one instruction, wait (bounded) for acceptance, return 1ns after the accept edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
      input logic [31:0] r1, input logic [31:0] r2,
      input logic [31:0] alu, input logic [31:0] jmp);
    int n;
    in_instr = ins; in_pc = pc; in_r1 = r1; in_r2 = r2;
    in_alu_res = alu; in_jmp_addr = jmp; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (!in_ready) begin
      $display("FAIL issue_timeout: in_ready=%b want 1", in_ready);
      miscompares++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (q_valid !== 1'b0) begin $display("FAIL rst_q_valid: got %b want 0", q_valid); miscompares++; end
    vectors++; if (redirect !== 1'b0) begin $display("FAIL rst_redirect: got %b want 0", redirect); miscompares++; end
    vectors++; if (bus_valid !== 1'b0) begin $display("FAIL rst_bus_valid: got %b want 0", bus_valid); miscompares++; end
    vectors++; if (q_res !== 32'd0) begin $display("FAIL rst_q_res: got %h want 0", q_res); miscompares++; end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready: got %b want 1", in_ready); miscompares++; end
  endtask

  task automatic test_hold;
    q_ready = 1'b0;
    issue(itype(12'd5, 3'b000, 5'd3, 7'h13), 32'h40, 32'd0, 32'd0, 32'd5, 32'd0);
    vectors++; if (q_valid !== 1'b1) begin $display("FAIL hold_valid: got %b want 1", q_valid); miscompares++; end
    vectors++; if (q_write_rd !== 1'b1) begin $display("FAIL hold_wr: got %b want 1", q_write_rd); miscompares++; end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (q_res !== 32'd5 || q_valid !== 1'b1) begin $display("FAIL hold_stable%0d: got %b/%h want 1/5", i, q_valid, q_res); miscompares++; end
      vectors++; if (in_ready !== 1'b0) begin $display("FAIL hold_in_ready%0d: got %b want 0", i, in_ready); miscompares++; end
      if (i < 2) begin @(posedge clk); #1; end
    end
    q_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin $display("FAIL hold_release_ready: got %b want 1", in_ready); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (q_valid !== 1'b0) begin $display("FAIL hold_drain: got %b want 0", q_valid); miscompares++; end
  endtask

  task automatic test_redirect;
    issue({20'd0, 5'd1, 7'h6F}, 32'h100, 32'd0, 32'd0, 32'hDEAD, 32'h200);
    vectors++; if (redirect !== 1'b1) begin $display("FAIL jal_redirect: got %b want 1", redirect); miscompares++; end
    vectors++; if (redirect_addr !== 32'h200) begin $display("FAIL jal_target: got %h want 200", redirect_addr); miscompares++; end
    vectors++; if (q_valid !== 1'b1 || q_res !== 32'h104) begin $display("FAIL jal_link: got %b/%h want 1/104", q_valid, q_res); miscompares++; end
    for (int k = 0; k < 3; k++) begin
      in_instr = itype(12'd1, 3'b000, 5'd3, 7'h13);
      in_pc = 32'h200 + 32'(4 * k);
      in_alu_res = 32'(11 * (k + 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (k == 0) begin
        vectors++; if (redirect !== 1'b0) begin $display("FAIL jal_pulse: got %b want 0", redirect); miscompares++; end
      end
      if (k < 2) begin
        vectors++; if (q_valid !== 1'b0) begin $display("FAIL shadow_kill%0d: got %b want 0", k, q_valid); miscompares++; end
      end else begin
        vectors++; if (q_valid !== 1'b1 || q_res !== 32'd33 || q_pc !== 32'h208) begin $display("FAIL shadow_retire: got %b/%h/%h want 1/21/208", q_valid, q_res, q_pc); miscompares++; end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_branch;
    issue(btype(3'b110), 32'h80, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h300);
    vectors++; if (redirect !== 1'b0 || q_write_rd !== 1'b0 || q_valid !== 1'b1) begin $display("FAIL bltu_not_taken: got %b/%b/%b want 0/0/1", redirect, q_write_rd, q_valid); miscompares++; end
    issue(btype(3'b100), 32'h84, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h300);
    vectors++; if (redirect !== 1'b1 || redirect_addr !== 32'h300) begin $display("FAIL blt_taken: got %b/%h want 1/300", redirect, redirect_addr); miscompares++; end
    for (int k = 0; k < 2; k++) begin
      issue(itype(12'd0, 3'b000, 5'd0, 7'h13), 32'h300, 32'd0, 32'd0, 32'd0, 32'd0);
      vectors++; if (q_valid !== 1'b0) begin $display("FAIL blt_shadow%0d: got %b want 0", k, q_valid); miscompares++; end
    end
    issue(itype(12'd4, 3'b000, 5'd1, 7'h67), 32'h50, 32'h1001, 32'd0, 32'd0, 32'h999);
    vectors++; if (redirect !== 1'b1 || redirect_addr !== 32'h1004) begin $display("FAIL jalr_target: got %b/%h want 1/1004", redirect, redirect_addr); miscompares++; end
    vectors++; if (q_res !== 32'h54) begin $display("FAIL jalr_link: got %h want 54", q_res); miscompares++; end
    for (int k = 0; k < 2; k++)
      issue(itype(12'd0, 3'b000, 5'd0, 7'h13), 32'h0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  logic [2:0]  md_f3[10]  = '{3'b100, 3'b101, 3'b001, 3'b100, 3'b110,
                              3'b111, 3'b000, 3'b011, 3'b010, 3'b110};
  logic [31:0] md_r1[10]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                              32'd7, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
  logic [31:0] md_r2[10]  = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
  logic [31:0] md_exp[10] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000, 32'd0,
                              32'd7, 32'hFFFF_FFD6, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  task automatic test_muldiv;
    int n;
    for (int i = 0; i < 10; i++) begin
      issue(mtype(md_f3[i]), 32'h400, md_r1[i], md_r2[i], 32'hBAD, 32'd0);
      n = 1;
      while (!q_valid && n < 100) begin
        @(posedge clk); #1; n++;
      end
      vectors++; if (n !== 33) begin $display("FAIL md_latency%0d: got %0d want 33", i, n); miscompares++; end
      vectors++; if (q_res !== md_exp[i] || q_write_rd !== 1'b1) begin $display("FAIL md_res%0d: got %h/%b want %h/1", i, q_res, q_write_rd, md_exp[i]); miscompares++; end
    end
  endtask

  task automatic test_load;
    int n;
    bus_ready = 1'b0;
    issue(itype(12'd3, 3'b000, 5'd5, 7'h03), 32'h500, 32'h1000, 32'd0, 32'd0, 32'd0);
    vectors++; if (bus_addr !== 32'h1000 || bus_lanes !== 4'b1000 || bus_wr !== 1'b0) begin $display("FAIL lb_req: got %h/%b/%b want 1000/1000/0", bus_addr, bus_lanes, bus_wr); miscompares++; end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus_valid === 1'b1) n++;
      if (i < 4) begin @(posedge clk); #1; end
    end
    vectors++; if (bus_addr !== 32'h1000 || bus_lanes !== 4'b1000) begin $display("FAIL lb_hold: got %h/%b want 1000/1000", bus_addr, bus_lanes); miscompares++; end
    bus_din = 32'h8012_3456;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    vectors++; if (n !== 5 || bus_valid !== 1'b0) begin $display("FAIL lb_valid_cycles: got %0d/%b want 5/0", n, bus_valid); miscompares++; end
    vectors++; if (q_valid !== 1'b1 || q_res !== 32'hFFFF_FF80 || q_write_rd !== 1'b1) begin $display("FAIL lb_data: got %b/%h/%b want 1/ffffff80/1", q_valid, q_res, q_write_rd); miscompares++; end
    bus_din = 32'h0000_8000;
    bus_ready = 1'b1;
    issue(itype(12'd0, 3'b101, 5'd6, 7'h03), 32'h504, 32'h1000, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    bus_ready = 1'b0;
    vectors++; if (q_res !== 32'h0000_8000) begin $display("FAIL lhu_data: got %h want 8000", q_res); miscompares++; end
  endtask

  task automatic test_store;
    bus_ready = 1'b1;
    issue(stype(12'd1, 3'b000), 32'h600, 32'h2000, 32'h0000_00AB, 32'd0, 32'd0);
    vectors++; if (bus_valid !== 1'b1 || bus_wr !== 1'b1 || bus_addr !== 32'h2000) begin $display("FAIL sb_req: got %b/%b/%h want 1/1/2000", bus_valid, bus_wr, bus_addr); miscompares++; end
    vectors++; if (bus_lanes !== 4'b0010 || bus_dout !== 32'hABAB_ABAB) begin $display("FAIL sb_lanes: got %b/%h want 0010/abababab", bus_lanes, bus_dout); miscompares++; end
    @(posedge clk); #1;
    bus_ready = 1'b0;
    vectors++; if (bus_valid !== 1'b0 || q_valid !== 1'b1 || q_write_rd !== 1'b0) begin $display("FAIL sb_done: got %b/%b/%b want 0/1/0", bus_valid, q_valid, q_write_rd); miscompares++; end
  endtask

  task automatic test_misalign;
    issue(stype(12'd2, 3'b010), 32'h700, 32'h1000, 32'h1234, 32'd0, 32'd0);
    vectors++; if (q_valid !== 1'b1 || q_misalign !== 1'b1 || q_write_rd !== 1'b0) begin $display("FAIL sw_misalign: got %b/%b/%b want 1/1/0", q_valid, q_misalign, q_write_rd); miscompares++; end
    vectors++; if (bus_valid !== 1'b0) begin $display("FAIL sw_no_bus: got %b want 0", bus_valid); miscompares++; end
    issue(itype(12'd1, 3'b010, 5'd5, 7'h03), 32'h704, 32'h1000, 32'd0, 32'd0, 32'd0);
    vectors++; if (q_misalign !== 1'b1 || q_write_rd !== 1'b0 || bus_valid !== 1'b0) begin $display("FAIL lw_misalign: got %b/%b/%b want 1/0/0", q_misalign, q_write_rd, bus_valid); miscompares++; end
    issue(itype(12'd0, 3'b000, 5'd4, 7'h13), 32'h708, 32'd0, 32'd0, 32'd9, 32'd0);
    vectors++; if (q_misalign !== 1'b0 || q_res !== 32'd9) begin $display("FAIL misalign_clear: got %b/%h want 0/9", q_misalign, q_res); miscompares++; end
  endtask

  task automatic test_reset_mid;
    int n;
    issue(mtype(3'b100), 32'h800, 32'd100, 32'd7, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (q_valid !== 1'b0 || q_res !== 32'd0 || redirect !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL rst_md: got %b/%h/%b/%b want 0/0/0/1", q_valid, q_res, redirect, in_ready); miscompares++; end
    #2 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (q_valid === 1'b1) n++;
    end
    vectors++; if (n !== 0) begin $display("FAIL rst_md_stale: got %0d want 0", n); miscompares++; end
    bus_ready = 1'b0;
    issue(stype(12'd0, 3'b010), 32'h900, 32'h3000, 32'h55, 32'd0, 32'd0);
    vectors++; if (bus_valid !== 1'b1 || bus_wr !== 1'b1) begin $display("FAIL mem_pre_rst: got %b/%b want 1/1", bus_valid, bus_wr); miscompares++; end
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus_valid !== 1'b0 || bus_wr !== 1'b0 || bus_lanes !== 4'd0 || q_valid !== 1'b0) begin $display("FAIL rst_mem: got %b/%b/%b/%b want 0/0/0000/0", bus_valid, bus_wr, bus_lanes, q_valid); miscompares++; end
    #2 rst = 1'b0;
    bus_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (q_valid === 1'b1 || bus_valid === 1'b1) n++;
    end
    bus_ready = 1'b0;
    vectors++; if (n !== 0 || in_ready !== 1'b1) begin $display("FAIL rst_mem_stale: got %0d/%b want 0/1", n, in_ready); miscompares++; end
  endtask

  initial begin
    test_reset;
    test_hold;
    test_redirect;
    test_branch;
    test_muldiv;
    test_load;
    test_store;
    test_misalign;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter MULDIV_EN, default 1, meaning RV32M multiply/divide support is present (0 = M-ops produce result 0).
REQ-002 SHALL have parameter SHADOW, default 1, meaning the number of accepted instructions discarded after each redirect (0..7).
REQ-003 SHALL have ports, clock and reset first; reset is rst, asynchronous, active-high; clock is clk:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid / in_ready  in / out  1 / 1  input handshake
in_instr, in_pc, in_r1, in_r2  in  32 each  instruction, its address, rs1 value, rs2 value
in_alu_res  in  32  result from the external ALU for base integer ops
in_jmp_addr  in  32  precomputed JAL/branch target
q_valid / q_ready  out / in  1 / 1  output handshake
q_instr, q_pc, q_res  out  32 each  retired instruction, its address, rd value
q_write_rd, q_misalign  out  1 each  rd write enable; misaligned load/store flag
redirect / redirect_addr  out / out  1 / 32  redirect pulse and target
bus_addr, bus_dout  out  32 each  data bus address and write data
bus_din  in  32  data bus read data
bus_lanes  out  4  byte-lane enables
bus_wr, bus_valid  out  1 each  write strobe and request valid
bus_ready  in  1  data bus completion

Function
REQ-004 SHALL implement FSM states IDLE, MULDIV and MEM.
REQ-005 SHALL drive in_ready = (state==IDLE) && (!q_valid || q_ready).
REQ-006 SHALL, once q_valid=1, hold q_valid and every q_* output stable until q_ready=1.
REQ-007 SHALL load single-cycle ops (non-M opcode 0x33, 0x13, 0x37, 0x17, 0x6F, 0x67, 0x63, 0x0F) into the output register on the accept edge, giving 1-cycle latency; q_res = in_alu_res, except JAL/JALR where q_res = pc+4.
REQ-008 SHALL set q_write_rd = (rd!=0) && opcode not in {0x63, 0x23, 0x0F} && !q_misalign.
REQ-009 SHALL, for JAL, pulse redirect for 1 cycle on the accept edge with redirect_addr = in_jmp_addr.
REQ-010 SHALL, for JALR, pulse redirect for 1 cycle on the accept edge with redirect_addr = (r1 + sext(imm12)) & ~1.
REQ-011 SHALL, for a branch, evaluate BEQ/BNE/BLT/BGE/BLTU/BGEU on r1/r2, and if taken pulse redirect for 1 cycle with redirect_addr = in_jmp_addr.
REQ-012 SHALL, on each redirect, load a kill counter with SHADOW.
REQ-013 SHALL consume each instruction accepted while the kill counter is nonzero (in_ready as normal), decrement the counter, and discard the instruction: no q_valid, no bus access, no FSM change.
REQ-014 SHALL, for an M-op (opcode 0x33, funct7 0000001) with MULDIV_EN=1, enter MULDIV and iterate 32 cycles (radix-2 shift-add or restoring division).
REQ-015 SHALL, at the end of the MULDIV iteration, load the output register and return to IDLE; total latency is 33 cycles.
REQ-016 SHALL handle MULH/MULHSU/MULHU signed/unsigned per RV32M and return the upper 32 bits.
REQ-017 SHALL, on divide by zero, return quotient 0xFFFFFFFF and remainder = dividend.
REQ-018 SHALL, for DIV/REM of 0x80000000 / -1, return quotient 0x80000000 and remainder 0.
REQ-019 SHALL compute the load/store address as r1 + sext(I-imm) for loads and r1 + sext(S-imm) for stores.
REQ-020 SHALL, for a load/store whose address is misaligned for its size, issue no bus access and complete in 1 cycle with q_misalign=1, q_write_rd=0.
REQ-021 SHALL, for an aligned load/store, enter MEM with bus_valid=1 and hold bus_addr, bus_lanes, bus_dout and bus_wr stable until bus_ready.
REQ-022 SHALL, on the bus_ready cycle, deassert bus_valid and load the output register on that edge.
REQ-023 SHALL select bus_lanes from size and addr[1:0] (byte 0001<<a, half 0011<<a, word 1111).
REQ-024 SHALL replicate store data across lanes.
REQ-025 SHALL extract loaded data from the addressed lanes, sign-extending LB/LH and zero-extending LBU/LHU.
REQ-026 SHALL drive bus_addr word-aligned as {addr[31:2], 2'b00}.

Reset
REQ-027 SHALL, on rst, asynchronously force state=IDLE, kill counter=0, q_valid=0, q_write_rd=0, q_misalign=0, redirect=0, bus_valid=0 and bus_wr=0; data registers clear to 0.
REQ-028 SHALL abandon any in-progress MULDIV or MEM operation on rst with no output produced; deasserting rst resumes in IDLE.

Verification
REQ-029 SHALL be verified by: ADDI result 5, q_ready=0 for 3 cycles -> q_valid=1, q_res=5 held stable; in_ready=0 until the q_ready cycle.
REQ-030 SHALL be verified by: JAL at pc 0x100 to 0x200 with SHADOW=2, followed by 3 ADDIs -> redirect pulse, redirect_addr=0x200, q_res=0x104; the first 2 ADDIs are discarded and the 3rd is retired.
REQ-031 SHALL be verified by: DIV 7/0, DIVU 0x80000000/0xFFFFFFFF, MULH -1*-1 -> 0xFFFFFFFF, 0, 0; each q_valid appears 33 cycles after accept.
REQ-032 SHALL be verified by: LB at address 0x1003, bus_din=0x80xxxxxx, bus_ready delayed 4 cycles -> bus_lanes=1000, bus_addr=0x1000, q_res=0xFFFFFF80, bus_valid held for 5 cycles.
REQ-033 SHALL be verified by: SW at address 0x1002 -> q_misalign=1, bus_valid never asserted, q_write_rd=0.
REQ-034 SHALL be verified by: rst asserted mid-MULDIV and mid-MEM -> all outputs at their reset values immediately; no stale q_valid after release.
